// File: rtl/bit_serializer.sv
// Purpose: parallel-to-serial front end; WIDTH-bit words in over valid/ready, one bit per clock out.
// Latency: first bit on out one edge after the accepting edge; back-to-back words stream with no gap.
// Backpressure: in_ready drops only while the holding register is full and the shifter is mid-word.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;
    logic             hold_valid_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;
    logic             load;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] shifted;

    // Handshake is driven from registered state only, so in_ready never depends on in_valid.
    assign last_bit  = (bit_cnt == LAST);
    assign load      = hold_valid && ((state == IDLE) || ((state == SHIFT) && last_bit));
    assign in_ready  = !hold_valid || load;
    assign accept    = in_valid && in_ready;

    // Bit selection follows the shift direction: the bit leaving next always sits at the output end.
    assign first_bit = MSB_FIRST ? hold_data[WIDTH-1] : hold_data[0];
    assign next_bit  = MSB_FIRST ? shift_reg[WIDTH-2] : shift_reg[1];
    assign shifted   = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};

    // Next-state values for the holding register flag and the FSM, shared by busy.
    always_comb begin
        hold_valid_nxt = hold_valid;
        state_nxt      = state;
        if (accept) begin
            hold_valid_nxt = 1'b1;
        end else if (load) begin
            hold_valid_nxt = 1'b0;
        end
        if (load) begin
            state_nxt = SHIFT;
        end else if ((state == SHIFT) && last_bit) begin
            state_nxt = IDLE;
        end
    end

    // Holding register: a word accepted on a load edge replaces the one moving into the shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else begin
            hold_valid <= hold_valid_nxt;
            if (accept) begin
                hold_data <= in_data;
            end
        end
    end

    // Shifter FSM with registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            out        <= IDLE_BIT;
            out_valid  <= 1'b0;
            word_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= hold_valid_nxt || (state_nxt == SHIFT);
            if (load) begin
                shift_reg  <= hold_data;
                bit_cnt    <= '0;
                out        <= first_bit;
                out_valid  <= 1'b1;
                word_start <= 1'b1;
            end else if ((state == SHIFT) && !last_bit) begin
                shift_reg  <= shifted;
                bit_cnt    <= bit_cnt + CW'(1);
                out        <= next_bit;
                word_start <= 1'b0;
            end else begin
                out        <= IDLE_BIT;
                out_valid  <= 1'b0;
                word_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first/idle-0 instance and an LSB-first/idle-1 instance share one input stream.
// Expected stream comes from a word-queue model: each accepted word occupies WIDTH consecutive bit slots.
// Directed scenarios first, then a randomized valid/data phase that exercises backpressure.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;

    logic rdy_a, out_a, ov_a, ws_a, busy_a;
    logic rdy_b, out_b, ov_b, ws_b, busy_b;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model: words waiting, word being emitted, and the bit slot on the line (-1 = none).
    logic [W-1:0] m_hold[$];
    logic [W-1:0] m_cur;
    int           m_pos;
    bit           m_acc;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
        .out(out_a), .out_valid(ov_a), .word_start(ws_a), .busy(busy_a)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
        .out(out_b), .out_valid(ov_b), .word_start(ws_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return (m_hold.size() == 0) || (m_pos == -1) || (m_pos == W - 1);
    endfunction

    task automatic model_reset();
        m_hold.delete();
        m_cur = '0;
        m_pos = -1;
        m_acc = 1'b0;
    endtask

    // One clock edge of the model: the held word starts as soon as the line is free.
    task automatic model_edge(input logic v, input logic [W-1:0] d);
        bit r;
        r = model_ready();
        if ((m_hold.size() > 0) && ((m_pos == -1) || (m_pos == W - 1))) begin
            m_cur = m_hold.pop_front();
            m_pos = 0;
        end else if (m_pos >= 0) begin
            m_pos = (m_pos == W - 1) ? -1 : m_pos + 1;
        end
        m_acc = v && r;
        if (m_acc) m_hold.push_back(d);
    endtask

    task automatic check_outputs(input string tag);
        logic act;
        act = (m_pos >= 0);
        check({tag, ".a.out"},        out_a,  act ? m_cur[W - 1 - m_pos] : 1'b0);
        check({tag, ".a.out_valid"},  ov_a,   act);
        check({tag, ".a.word_start"}, ws_a,   m_pos == 0);
        check({tag, ".a.busy"},       busy_a, act || (m_hold.size() > 0));
        check({tag, ".b.out"},        out_b,  act ? m_cur[m_pos] : 1'b1);
        check({tag, ".b.out_valid"},  ov_b,   act);
        check({tag, ".b.word_start"}, ws_b,   m_pos == 0);
        check({tag, ".b.busy"},       busy_b, act || (m_hold.size() > 0));
    endtask

    // Drive one cycle of input, check in_ready before the edge and all outputs after it.
    task automatic tick(input string tag, input logic v, input logic [W-1:0] d);
        in_valid = v;
        in_data  = d;
        #1;
        check({tag, ".a.in_ready"}, rdy_a, model_ready());
        check({tag, ".b.in_ready"}, rdy_b, model_ready());
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle_ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, 1'b0, $urandom_range(0, 255));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".a.out"},        out_a,  1'b0);
        check({tag, ".a.out_valid"},  ov_a,   1'b0);
        check({tag, ".a.word_start"}, ws_a,   1'b0);
        check({tag, ".a.busy"},       busy_a, 1'b0);
        check({tag, ".a.in_ready"},   rdy_a,  1'b1);
        check({tag, ".b.out"},        out_b,  1'b1);
        check({tag, ".b.out_valid"},  ov_b,   1'b0);
        check({tag, ".b.busy"},       busy_b, 1'b0);
        check({tag, ".b.in_ready"},   rdy_b,  1'b1);
    endtask

    initial begin
        int tries;
        model_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Single word 0xD0: MSB-first 1,1,0,1,0,0,0,0 on a; LSB-first 0,0,0,0,1,0,1,1 on b.
        tick("single", 1'b1, 8'hD0);
        idle_ticks("single", 10);

        // Back-to-back 0xD0 then 0xB5: the second word goes in on the first word's load edge.
        tick("b2b", 1'b1, 8'hD0);
        tries = 0;
        do begin
            tick("b2b", 1'b1, 8'hB5);
            tries++;
        end while (!m_acc && tries < 20);
        check("b2b.accept_in_bound", m_acc, 1'b1);
        idle_ticks("b2b", 18);

        // 0x0B: LSB-first instance emits 1,1,0,1,0,0,0,0.
        tick("lsb", 1'b1, 8'h0B);
        idle_ticks("lsb", 10);

        // Randomized valid/data with frequent backpressure; data changes while not ready.
        for (int i = 0; i < 400; i++) begin
            tick("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 255));
        end
        idle_ticks("drain", 12);

        // Reset after the third bit of 0xFF while 0xAA is held.
        tick("rst_mid", 1'b1, 8'hFF);
        tick("rst_mid", 1'b1, 8'hAA);
        tick("rst_mid", 1'b0, 8'h00);
        tick("rst_mid", 1'b0, 8'h00);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_mid.async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_reset_state("rst_mid.held");
        rst_n = 1'b1;
        tick("after_rst", 1'b1, 8'h0D);
        idle_ticks("after_rst", 10);

        // Long idle: lines stay at their idle level.
        idle_ticks("idle", 20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on a single-bit line that drives a detector's serial `in`. A one-word holding register lets back-to-back words stream with no idle cycles. When no word is available, the line is driven with a fixed idle bit.

## Interface
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is shifted first; 0 = bit 0 is shifted first.
- IDLE_BIT, 0: value driven on `out` whenever `out_valid` = 0.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- out  output  1  serial bit, registered; connects to the detector's `in`.
- out_valid  output  1  `out` carries a data bit, registered.
- word_start  output  1  high for exactly the first bit of each word, registered.
- busy  output  1  holding register or shifter occupied, registered.

## Operation
- Storage:
  - hold_data / hold_valid: one-word holding register.
  - shift_reg (WIDTH) + bit_cnt (clog2(WIDTH) bits).
  - FSM state: IDLE or SHIFT.
- Accept: a word is taken on a rising edge with in_valid && in_ready. in_data is captured into hold_data and hold_valid is set.
- in_ready = !hold_valid || load. This is combinational from registered state only; it has no path from in_valid.
- load = hold_valid && (state == IDLE || (state == SHIFT && bit_cnt == WIDTH-1)).
- On load:
  - shift_reg <= hold_data, bit_cnt <= 0, state <= SHIFT.
  - out <= first bit per MSB_FIRST, out_valid <= 1, word_start <= 1.
  - hold_valid is cleared unless a new word is accepted on the same edge; in that case hold_valid stays 1 with the new data.
- SHIFT, bit_cnt < WIDTH-1:
  - Shift one position (left if MSB_FIRST, right otherwise).
  - out <= next bit, bit_cnt++, word_start <= 0.
- SHIFT, bit_cnt == WIDTH-1, no load: state <= IDLE, out <= IDLE_BIT, out_valid <= 0, word_start <= 0.
- IDLE with no word held: out = IDLE_BIT, out_valid = 0.
- busy <= next hold_valid || next state == SHIFT.
- Words are never reordered, dropped, or truncated, except by reset.

## Timing
- Reset values (asserted asynchronously; held while rst_n = 0):
  - state IDLE, hold_valid 0, bit_cnt 0, shift_reg 0.
  - out = IDLE_BIT, out_valid 0, word_start 0, busy 0.
  - in_ready 1.
- Reset release: first accept possible on the first rising edge with rst_n = 1.
- Latency from IDLE and empty:
  - Word accepted on edge E0.
  - Loaded on E0+1; after E0+1, bit 0 is on `out` with word_start = 1.
  - Bit k is on `out` after edge E0+1+k.
  - Last bit is on `out` after E0+WIDTH.
- Streaming: if the next word is held before the last-bit edge, its first bit follows the previous word's last bit in the very next cycle. Sustained throughput is one word per WIDTH cycles with zero gap cycles.
- Backpressure: with the shifter busy and hold full, in_ready = 0 until the load edge. In the load cycle in_ready = 1, so a new word can be accepted on that same edge.
- in_valid high while in_ready = 0: no capture; in_data may change freely.
- Reset mid-word: the partial word and the held word are discarded immediately. out = IDLE_BIT in the same cycle; no remaining bits are emitted.
- WIDTH = 2 boundary: a load occurs every other cycle and the stream stays gap-free.

## Test plan
- Single word, WIDTH=8, MSB_FIRST=1, in_data=8'hD0 accepted on E0:
  - out = 1,1,0,1,0,0,0,0 after edges E0+1..E0+8; word_start only after E0+1.
  - out_valid 0 and out 0 after E0+9.
  - A downstream 1101 detector fires once.
- Back-to-back words 8'hD0 then 8'hB5, in_valid held high:
  - Second word accepted in the load cycle of the first.
  - 16 contiguous valid bits; word_start after E0+1 and E0+9.
  - in_ready low while hold is full, except in load cycles.
- MSB_FIRST=0, in_data=8'h0B: out = 1,1,0,1,0,0,0,0; word_start on the first bit.
- Backpressure: in_valid held high with changing in_data while in_ready = 0 → only words present on accepting edges appear on out, in order, none duplicated.
- Reset asserted after the 3rd bit of 8'hFF with a word held:
  - out = IDLE_BIT, out_valid 0, busy 0, in_ready 1 immediately.
  - After release, a new word 8'h0D is serialized cleanly from its bit 0.
- IDLE_BIT=1, no input for 20 cycles → out constantly 1, out_valid 0, busy 0.
